// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Conditions one raw push-button input: two-flop synchroniser,
//               counter-based debouncer FSM, registered press/release strobes
//               and an 8-bit wrapping press counter.
//               Optional auto-repeat of press strobes while the button is held
//               is built when the macro BTN_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_cnt
);

    // Debounce FSM encoding
    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_PRESSED      = 2'd2;
    localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

    // Last count value before a level change is accepted
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity checks, evaluated at elaboration
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
        $error("btn_conditioner: REPEAT_DELAY and REPEAT_RATE must be positive");
    end

    logic             r_s1;
    logic             r_s2;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_evt;
    logic             w_release_evt;
    logic             w_press_fire;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic [7:0]       r_press_cnt;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= BTN;
            r_s2 <= r_s1;
        end
    end

    // FSM state and debounce counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a level change needs DEBOUNCE_CYCLES further stable samples
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_evt   = 1'b0;
        w_release_evt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_s2) begin
                    w_state_nxt = c_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            c_PRESS_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = c_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_PRESSED;
                    w_press_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_PRESSED: begin
                if (!r_s2) begin
                    w_state_nxt = c_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            c_RELEASE_WAIT: begin
                if (r_s2) begin
                    w_state_nxt = c_PRESSED;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt   = c_IDLE;
                    w_release_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: level is high while pressed or waiting out a release
    always_comb begin
        btn_level = (r_state == c_PRESSED) || (r_state == c_RELEASE_WAIT);
    end

`ifdef BTN_REPEAT_EN
    localparam int c_REP_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RCNT_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
    localparam logic [c_RCNT_W-1:0] c_DELAY_LAST = c_RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RCNT_W-1:0] c_RATE_LAST  = c_RCNT_W'(REPEAT_RATE - 1);

    logic [c_RCNT_W-1:0] r_rcnt;
    logic                r_rep_armed;
    logic                w_hold;
    logic                w_rep_evt;

    // Repeat timing runs only while settled in PRESSED with the input still high;
    // the first repeat waits REPEAT_DELAY, later ones REPEAT_RATE
    always_comb begin
        w_hold    = (r_state == c_PRESSED) && r_s2;
        w_rep_evt = w_hold && (r_rcnt == (r_rep_armed ? c_RATE_LAST : c_DELAY_LAST));
    end

    // Repeat counter: held clear outside PRESSED so each entry restarts the delay
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rcnt      <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_hold) begin
            r_rcnt      <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_evt) begin
            r_rcnt      <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rcnt <= r_rcnt + c_RCNT_W'(1);
        end
    end

    // Press strobe sources: accepted press plus auto-repeat
    always_comb begin
        w_press_fire = w_press_evt | w_rep_evt;
    end
`else
    // Press strobe source: accepted press only
    always_comb begin
        w_press_fire = w_press_evt;
    end
`endif

    // Registered strobes and wrapping press counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_press_cnt     <= 8'd0;
        end else begin
            r_press_pulse   <= w_press_fire;
            r_release_pulse <= w_release_evt;
            r_press_cnt     <= r_press_cnt + {7'd0, r_press_pulse};
        end
    end

    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign press_cnt     = r_press_cnt;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Self-checking bench for btn_conditioner: directed vector table,
//               hand-written wrap/reset/repeat sequences and randomized button
//               activity compared against a run-length reference model.
//               Honours BTN_REPEAT_EN for the repeat expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int c_D  = 4;
    localparam int c_RD = 20;
    localparam int c_RR = 8;
    localparam int c_NV = 44;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BTN = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .REPEAT_DELAY    (c_RD),
        .REPEAT_RATE     (c_RR)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .BTN           (BTN),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_cnt     (press_cnt)
    );

    // Reference model: level flips once a sample two edges old has disagreed
    // with the current level for DEBOUNCE_CYCLES+1 consecutive edges
    bit         m_h0, m_h1;
    bit         m_lvl;
    int         m_opp;
    int         m_t;
    bit         m_pp, m_rp;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_h0 = 0; m_h1 = 0; m_lvl = 0; m_opp = 0; m_t = 0;
        m_pp = 0; m_rp = 0; m_cnt = 8'd0;
    endtask

    task automatic model_edge(input bit b);
        bit v;
        v    = m_h1;
        m_h1 = m_h0;
        m_h0 = b;
        m_cnt = m_cnt + (m_pp ? 8'd1 : 8'd0);
        m_pp = 0;
        m_rp = 0;
        if (v != m_lvl) begin
            m_opp++;
            if (m_opp == c_D + 1) begin
                m_lvl = v;
                m_opp = 0;
                if (v) begin
                    m_pp = 1;
                    m_t  = 0;
                end else begin
                    m_rp = 1;
                end
            end
        end else begin
            if (m_lvl) begin
                if (m_opp > 0) begin
                    m_t = 0;
                end else begin
                    m_t++;
`ifdef BTN_REPEAT_EN
                    if (m_t == c_RD || (m_t > c_RD && (m_t - c_RD) % c_RR == 0))
                        m_pp = 1;
`endif
                end
            end
            m_opp = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("level",     32'(btn_level),     32'(m_lvl));
        chk("press",     32'(press_pulse),   32'(m_pp));
        chk("release",   32'(release_pulse), 32'(m_rp));
        chk("press_cnt", 32'(press_cnt),     32'(m_cnt));
        chk("exclusive", 32'(press_pulse & release_pulse), 32'd0);
    endtask

    // Drive one input value, clock once, advance the model, optionally compare
    task automatic tick(input bit b, input bit cmp);
        BTN = b;
        @(posedge CLK);
        model_edge(b);
        #1;
        if (cmp) compare_model();
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #3;
        RST = 1'b1;
        #1;
        chk("rst_level",   32'(btn_level),     32'd0);
        chk("rst_press",   32'(press_pulse),   32'd0);
        chk("rst_release", 32'(release_pulse), 32'd0);
        chk("rst_cnt",     32'(press_cnt),     32'd0);
        #10;
        RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit btn;
        bit lvl;
        bit pp;
        bit rp;
        int cnt;
    } vec_t;

    vec_t vecs[c_NV];

    initial begin
        int idx;
        int q_off[$];
        int e_off[$];
        int cyc;
        bit val;
        bit found;

        // Directed table: clean press, release, short bounce, toggling burst
        for (int i = 0; i < c_NV; i++) begin
            if (i <= 7)       vecs[i].btn = 1;
            else if (i <= 15) vecs[i].btn = 0;
            else if (i <= 17) vecs[i].btn = 1;
            else if (i <= 25) vecs[i].btn = 0;
            else if (i <= 35) vecs[i].btn = (i % 2 == 0);
            else              vecs[i].btn = 1;
            vecs[i].lvl = (i >= 6 && i <= 13) || (i >= 42);
            vecs[i].pp  = (i == 6) || (i == 42);
            vecs[i].rp  = (i == 14);
            vecs[i].cnt = (i < 7) ? 0 : ((i < 43) ? 1 : 2);
        end

        BTN = 1'b0;
        do_reset();

        for (int i = 0; i < c_NV; i++) begin
            tick(vecs[i].btn, 0);
            chk($sformatf("vec%0d_level", i),   32'(btn_level),     32'(vecs[i].lvl));
            chk($sformatf("vec%0d_press", i),   32'(press_pulse),   32'(vecs[i].pp));
            chk($sformatf("vec%0d_release", i), 32'(release_pulse), 32'(vecs[i].rp));
            chk($sformatf("vec%0d_cnt", i),     32'(press_cnt),     32'(vecs[i].cnt));
        end

        // 256 clean presses wrap the counter back to zero
        BTN = 1'b0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) tick(1, 1);
            for (int i = 0; i < 8; i++) tick(0, 1);
        end
        chk("cnt_wrap", 32'(press_cnt), 32'd0);

        // Reset while the button is held, then the full press sequence reruns
        for (int i = 0; i < 10; i++) tick(1, 1);
        chk("held_before_reset", 32'(btn_level), 32'd1);
        do_reset();
        idx = -1;
        for (int i = 0; i < 16; i++) begin
            tick(1, 1);
            if (press_pulse === 1'b1 && idx < 0) idx = i;
        end
        chk("press_after_reset_edge", 32'(idx), 32'd6);
        for (int i = 0; i < 10; i++) tick(0, 1);

        // Long hold: repeat strobes only when the feature is built
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1, 1);
            if (press_pulse === 1'b1) found = 1;
        end
        chk("hold_press_seen", 32'(found), 32'd1);
        q_off.delete();
        q_off.push_back(0);
        for (int j = 1; j < 60; j++) begin
            tick(1, 1);
            if (press_pulse === 1'b1) q_off.push_back(j);
        end
`ifdef BTN_REPEAT_EN
        e_off = '{0, 20, 28, 36, 44, 52};
`else
        e_off = '{0};
`endif
        chk("hold_pulse_count", 32'(q_off.size()), 32'(e_off.size()));
        for (int i = 0; i < e_off.size() && i < q_off.size(); i++)
            chk($sformatf("hold_pulse%0d_offset", i), 32'(q_off[i]), 32'(e_off[i]));
        chk("hold_cnt", 32'(press_cnt), 32'(e_off.size()));
        for (int i = 0; i < 12; i++) tick(0, 1);

        // Randomized bouncing and holding against the model
        do_reset();
        cyc = 0;
        val = 0;
        while (cyc < 2000) begin
            int len;
            val = ~val;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 45))
                                              : int'($urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) do_reset();
            for (int i = 0; i < len; i++) begin
                tick(val, 1);
                cyc++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
